// File: rtl/dmem_arbiter.sv
// Purpose : single-port data-memory arbiter/sequencer shared by the CPU MEM stage and the IP data port.
// Latency : request-to-done WAIT_CYC+1 cycles; one IDLE cycle between accesses (WAIT_CYC+2 per access).
// Backpr. : requests are levels held until done; cpu_stall holds the MEM stage, ip_grant shows IP ownership.
// Option  : define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
module dmem_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 32,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_stall,
   input  logic              ip_req,
   input  logic              ip_rw,
   input  logic [ADDR_W-1:0] ip_addr,
   input  logic [DATA_W-1:0] ip_wdata,
   output logic [DATA_W-1:0] ip_rdata,
   output logic              ip_done,
   output logic              ip_grant,
   output logic              mem_ena,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       owner;     // 0 = CPU, 1 = IP
   logic       load;      // latch a new request this edge
   logic       fin;       // last ACCESS cycle: close the window this edge
   logic       pick_ip;   // winner of the current arbitration

`ifdef DMEM_ARB_RR_EN
   logic last_ip;         // owner of the most recent grant

   // Remember who was granted last so the other side wins the next tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last_ip <= 1'b1;
      else if (load) last_ip <= pick_ip;
   end

   // On a tie, the side that did not get the last grant goes first.
   always_comb begin
      pick_ip = ip_req & (~cpu_req | ~last_ip);
   end
`else
   // Fixed priority: CPU wins every tie.
   always_comb begin
      pick_ip = ip_req & ~cpu_req;
   end
`endif

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; the counter runs WAIT_CYC-1 down to 0 across the ACCESS window.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req | ip_req) begin
               load      = 1'b1;
               cnt_nxt   = 4'(WAIT_CYC - 1);
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               fin       = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Latch the winner's request at grant; drop the strobes and capture read data at window end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= 1'b0;
         mem_ena   <= 1'b0;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         ip_rdata  <= '0;
      end else if (load) begin
         owner     <= pick_ip;
         mem_ena   <= 1'b1;
         mem_rw    <= pick_ip ? ip_rw    : cpu_rw;
         mem_addr  <= pick_ip ? ip_addr  : cpu_addr;
         mem_wdata <= pick_ip ? ip_wdata : cpu_wdata;
      end else if (fin) begin
         mem_ena <= 1'b0;
         mem_rw  <= 1'b0;
         if (!mem_rw) begin
            if (owner) ip_rdata  <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
         end
      end
   end

   // Done pulses and grant decode straight from state, so reset clears them immediately.
   always_comb begin
      cpu_done  = (state == RESP) & ~owner;
      ip_done   = (state == RESP) &  owner;
      ip_grant  = (state != IDLE) &  owner;
      cpu_stall = cpu_req & ~cpu_done;
   end

endmodule
